dmem_ctrl: RTL

Data-memory access controller between the MEM stage and the single-port synchronous data SRAM. It accepts one load or store request at a time over a valid/ready handshake and checks alignment. It drives the `data_sram_*` port with a word address, byte-write mask and replicated write data, then returns a sign- or zero-extended load result over a valid/ready response channel. One request is in flight at most; the MEM stage stalls on `req_ready`.

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_ctrl_load_align.sv | 26 ++
 rtl/dmem_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and store-path helpers for the data-memory
// access controller.
package dmem_pkg;

  localparam logic [2:0] MODE_B = 3'b001;
  localparam logic [2:0] MODE_H = 3'b010;
  localparam logic [2:0] MODE_W = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Byte-write mask for a store of the given size at byte offset off.
  function automatic logic [3:0] store_mask(input logic [2:0] mode, input logic [1:0] off);
    case (mode)
      MODE_B:  store_mask = 4'b0001 << off;
      MODE_H:  store_mask = off[1] ? 4'b1100 : 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // Right-justified store data copied into every lane it could land in.
  function automatic logic [31:0] lane_rep(input logic [2:0] mode, input logic [31:0] data);
    case (mode)
      MODE_B:  lane_rep = {4{data[7:0]}};
      MODE_H:  lane_rep = {2{data[15:0]}};
      default: lane_rep = data;
    endcase
  endfunction

  // Illegal size encoding or an address not aligned to the access size.
  function automatic logic req_bad(input logic [2:0] mode, input logic [1:0] off);
    case (mode)
      MODE_B:  req_bad = 1'b0;
      MODE_H:  req_bad = off[0];
      MODE_W:  req_bad = (off != 2'b00);
      default: req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_load_align.sv
// Load-path lane extraction and sign/zero extension of an SRAM read word.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  mode,
  input  logic        us,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [7:0]  byte_f;
  logic [15:0] half_f;

  always_comb begin
    byte_f = rdata[{off, 3'b000} +: 8];
    half_f = off[1] ? rdata[31:16] : rdata[15:0];
    // NOTE: every path assigns result (default arm included), so no latch is inferred.
    case (mode)
      MODE_B:  result = {{24{~us & byte_f[7]}}, byte_f};
      MODE_H:  result = {{16{~us & half_f[15]}}, half_f};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding load/store controller between the MEM stage and a
// single-port synchronous data SRAM.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic              req_us,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_we,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic [31:0]       data_sram_rdata
);

  state_e      state, state_nxt;
  logic        accept, bad;
  logic        r_we, r_us;
  logic [2:0]  r_mode;
  logic [1:0]  r_off;
  logic [31:0] load_val;

  assign bad    = req_bad(req_mode, req_addr[1:0]);
  assign accept = req_ready & req_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = bad ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT:   state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
  end

  load_align u_load_align (
    .rdata  (data_sram_rdata),
    .mode   (r_mode),
    .us     (r_us),
    .off    (r_off),
    .result (load_val)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_we            <= 1'b0;
      r_us            <= 1'b0;
      r_mode          <= MODE_W;
      r_off           <= 2'b00;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      data_sram_en    <= 1'b0;
      data_sram_we    <= '0;
      data_sram_addr  <= '0;
      data_sram_wdata <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values; the SRAM
      // port defaults to zero each cycle and is only loaded on an accept edge,
      // which keeps it live for exactly the ACCESS cycle.
      data_sram_en    <= 1'b0;
      data_sram_we    <= '0;
      data_sram_addr  <= '0;
      data_sram_wdata <= '0;
      if (accept) begin
        r_we       <= req_we;
        r_us       <= req_us;
        r_mode     <= req_mode;
        r_off      <= req_addr[1:0];
        resp_rdata <= '0;
        resp_err   <= bad;
        if (!bad) begin
          data_sram_en    <= 1'b1;
          data_sram_we    <= req_we ? store_mask(req_mode, req_addr[1:0]) : 4'b0000;
          data_sram_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
          data_sram_wdata <= req_we ? lane_rep(req_mode, req_wdata) : 32'h0;
        end
      end
      if (state == ST_WAIT) resp_rdata <= load_val;
    end
  end

endmodule
